// File: rtl/rc4_ksa_if.sv
// RC4 key-scheduling bus: start/finish handshake, latched key input and
// the S-RAM port (address/data/wen out, q_data in) plus ownership flags.
// With KSA_CYCLE_COUNT_EN defined the bus also carries cycle_count.
// master: the key-search controller / RAM side.  slave: the rc4_ksa block.
interface rc4_ksa_if #(
    parameter int KEY_LEN = 3
);
    logic                   start_sig;
    logic [8*KEY_LEN-1:0]   secret_key;
    logic [7:0]             q_data;
    logic                   finish;
    logic                   ksa_mem_handler;
    logic [1:0]             memory_sel;
    logic [7:0]             address;
    logic [7:0]             data;
    logic                   wen;
`ifdef KSA_CYCLE_COUNT_EN
    logic [15:0]            cycle_count;
`endif

    modport master (
        output start_sig,
        output secret_key,
        output q_data,
        input  finish,
        input  ksa_mem_handler,
        input  memory_sel,
        input  address,
        input  data,
`ifdef KSA_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        input  wen
    );

    modport slave (
        input  start_sig,
        input  secret_key,
        input  q_data,
        output finish,
        output ksa_mem_handler,
        output memory_sel,
        output address,
        output data,
`ifdef KSA_CYCLE_COUNT_EN
        output cycle_count,
`endif
        output wen
    );
endinterface

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage.
// Fills the S-RAM with the identity permutation (256 writes), then runs the
// 256 KSA swap iterations j = j + S[i] + key[i mod KEY_LEN]; swap(S[i], S[j]).
// Each swap iteration takes 10 cycles: the RAM has a one-cycle registered read
// and every RAM-facing output is itself registered, so each read needs a
// setup cycle, a wait cycle and a sample cycle.
// Key byte n is secret_key[8*(KEY_LEN-n)-1 -: 8] (MSB byte first); the key is
// latched in START so later changes on secret_key do not affect a run.
// Optional feature: define KSA_CYCLE_COUNT_EN to add the 16-bit cycle_count
// output (cycles from START up to DONE, held in DONE).
module rc4_ksa #(
    parameter int KEY_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    rc4_ksa_if.slave    ksa_bus
);

    localparam int KIW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KIW-1:0] KEY_LAST = KIW'(KEY_LEN - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_INIT     = 4'd2;
    localparam logic [3:0] S_SETUP_I  = 4'd3;
    localparam logic [3:0] S_WAIT_I   = 4'd4;
    localparam logic [3:0] S_SAMPLE_I = 4'd5;
    localparam logic [3:0] S_ADD_J    = 4'd6;
    localparam logic [3:0] S_SETUP_J  = 4'd7;
    localparam logic [3:0] S_WAIT_J   = 4'd8;
    localparam logic [3:0] S_SAMPLE_J = 4'd9;
    localparam logic [3:0] S_WRITE_I  = 4'd10;
    localparam logic [3:0] S_WRITE_J  = 4'd11;
    localparam logic [3:0] S_NEXT     = 4'd12;
    localparam logic [3:0] S_DONE     = 4'd13;

    // Control state
    logic [3:0]             state_q,   state_d;
    logic [7:0]             i_q,       i_d;
    logic [7:0]             j_q,       j_d;
    logic [7:0]             s_i_q,     s_i_d;
    logic [7:0]             s_j_q,     s_j_d;
    logic [KIW-1:0]         key_idx_q, key_idx_d;
    logic [8*KEY_LEN-1:0]   key_q,     key_d;

    // Registered outputs
    logic                   wen_q,     wen_d;
    logic [7:0]             address_q, address_d;
    logic [7:0]             data_q,    data_d;
    logic                   finish_q,  finish_d;
    logic                   own_q,     own_d;

    // Key split into bytes, byte 0 being the most significant one
    logic [7:0]             key_byte [KEY_LEN];
    logic [7:0]             key_sel;

    genvar gi;
    generate
        for (gi = 0; gi < KEY_LEN; gi++) begin : g_key_byte
            assign key_byte[gi] = key_q[8*(KEY_LEN-gi)-1 -: 8];
        end
    endgenerate

    // Select the key byte for the current iteration (explicit mux keeps
    // unused index codes harmless for non-power-of-two key lengths)
    always_comb begin
        key_sel = 8'd0;
        for (int n = 0; n < KEY_LEN; n++) begin
            if (key_idx_q == KIW'(n)) begin
                key_sel = key_byte[n];
            end
        end
    end

    // FSM next state and datapath updates
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        s_i_d     = s_i_q;
        s_j_d     = s_j_q;
        key_idx_d = key_idx_q;
        key_d     = key_q;

        case (state_q)
            S_IDLE: begin
                if (ksa_bus.start_sig) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                key_d     = ksa_bus.secret_key;
                i_d       = 8'd0;
                j_d       = 8'd0;
                key_idx_d = '0;
                state_d   = S_INIT;
            end
            S_INIT: begin
                // i wraps 255 -> 0, which is exactly the first swap index
                i_d = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    state_d = S_SETUP_I;
                end
            end
            S_SETUP_I:  state_d = S_WAIT_I;
            S_WAIT_I:   state_d = S_SAMPLE_I;
            S_SAMPLE_I: begin
                s_i_d   = ksa_bus.q_data;
                state_d = S_ADD_J;
            end
            S_ADD_J: begin
                j_d     = j_q + s_i_q + key_sel;
                state_d = S_SETUP_J;
            end
            S_SETUP_J:  state_d = S_WAIT_J;
            S_WAIT_J:   state_d = S_SAMPLE_J;
            S_SAMPLE_J: begin
                s_j_d   = ksa_bus.q_data;
                state_d = S_WRITE_I;
            end
            S_WRITE_I:  state_d = S_WRITE_J;
            S_WRITE_J:  state_d = S_NEXT;
            S_NEXT: begin
                if (i_q == 8'd255) begin
                    state_d = S_DONE;
                end else begin
                    i_d       = i_q + 8'd1;
                    key_idx_d = (key_idx_q == KEY_LAST) ? '0 : key_idx_q + KIW'(1);
                    state_d   = S_SETUP_I;
                end
            end
            S_DONE: begin
                // Four-phase handshake: wait for the requester to drop start
                if (!ksa_bus.start_sig) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state; results land in the output flops
    always_comb begin
        own_d     = (state_q != S_IDLE) && (state_q != S_DONE);
        wen_d     = 1'b0;
        address_d = address_q;
        data_d    = 8'd0;
        // finish is set on the first DONE cycle unconditionally, and cleared
        // on the same edge that sees start_sig low after it was shown
        finish_d  = (state_q == S_DONE) && !(finish_q && !ksa_bus.start_sig);

        case (state_q)
            S_IDLE, S_START, S_DONE: begin
                address_d = 8'd0;
            end
            S_INIT: begin
                wen_d     = 1'b1;
                address_d = i_q;
                data_d    = i_q;
            end
            S_SETUP_I, S_WAIT_I, S_SAMPLE_I: begin
                address_d = i_q;
            end
            S_SETUP_J, S_WAIT_J, S_SAMPLE_J: begin
                address_d = j_q;
            end
            S_WRITE_I: begin
                wen_d     = 1'b1;
                address_d = i_q;
                data_d    = s_j_q;
            end
            S_WRITE_J: begin
                wen_d     = 1'b1;
                address_d = j_q;
                data_d    = s_i_q;
            end
            default: begin
                address_d = address_q;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            s_i_q     <= 8'd0;
            s_j_q     <= 8'd0;
            key_idx_q <= '0;
            key_q     <= '0;
            wen_q     <= 1'b0;
            address_q <= 8'd0;
            data_q    <= 8'd0;
            finish_q  <= 1'b0;
            own_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            s_i_q     <= s_i_d;
            s_j_q     <= s_j_d;
            key_idx_q <= key_idx_d;
            key_q     <= key_d;
            wen_q     <= wen_d;
            address_q <= address_d;
            data_q    <= data_d;
            finish_q  <= finish_d;
            own_q     <= own_d;
        end
    end

    assign ksa_bus.wen             = wen_q;
    assign ksa_bus.address         = address_q;
    assign ksa_bus.data            = data_q;
    assign ksa_bus.finish          = finish_q;
    assign ksa_bus.ksa_mem_handler = own_q;
    assign ksa_bus.memory_sel      = {1'b0, own_q};

`ifdef KSA_CYCLE_COUNT_EN
    logic [15:0] cycle_count_q, cycle_count_d;

    // Counts every cycle from START through the last NEXT, then holds
    always_comb begin
        cycle_count_d = cycle_count_q;
        if ((state_q == S_IDLE) && ksa_bus.start_sig) begin
            cycle_count_d = 16'd0;
        end else if ((state_q != S_IDLE) && (state_q != S_DONE)) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= 16'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign ksa_bus.cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_rc4_ksa.sv
// Testbench for rc4_ksa: synchronous S-RAM model, write-port monitor and a
// plain software RC4 KSA reference.
module tb_rc4_ksa;

    localparam int KEY_LEN = 3;
    localparam int LOG_SZ  = 16384;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rc4_ksa_if #(.KEY_LEN(KEY_LEN)) bus ();

    rc4_ksa #(.KEY_LEN(KEY_LEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .ksa_bus (bus)
    );

    // Synchronous RAM, one-cycle registered read
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.wen) mem[bus.address] <= bus.data;
        bus.q_data <= mem[bus.address];
    end

    // Write monitor, sampled mid-cycle
    int         wlog_n = 0;
    logic [7:0] wlog_a [LOG_SZ];
    logic [7:0] wlog_d [LOG_SZ];
    always @(negedge clk) begin
        if (bus.wen === 1'b1) begin
            wlog_a[wlog_n % LOG_SZ] <= bus.address;
            wlog_d[wlog_n % LOG_SZ] <= bus.data;
            wlog_n <= wlog_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference model: expected final S and the full expected write stream
    logic [7:0] exp_s  [256];
    logic [7:0] exp_wa [768];
    logic [7:0] exp_wd [768];

    task automatic model_ksa(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] j;
        logic [7:0] t;
        int n;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int i = 0; i < 256; i++) begin
            s[i] = 8'(i);
            exp_wa[i] = 8'(i);
            exp_wd[i] = 8'(i);
        end
        j = 8'd0;
        n = 256;
        for (int i = 0; i < 256; i++) begin
            j = j + s[i] + kb[i % 3];
            exp_wa[n]     = 8'(i);
            exp_wd[n]     = s[j];
            exp_wa[n + 1] = j;
            exp_wd[n + 1] = s[i];
            n += 2;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int i = 0; i < 256; i++) exp_s[i] = s[i];
    endtask

    // Start a run and wait (bounded) for finish; lat counts edges after the
    // edge that sampled start_sig=1
    task automatic start_and_wait(input logic [23:0] key, input bit hold, input int chg_at,
                                  input logic [23:0] key2, output int lat, output int base);
        base = wlog_n;
        bus.secret_key = key;
        bus.start_sig  = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start_sig = 1'b0;
        lat = 0;
        while (bus.finish !== 1'b1 && lat < 4000) begin
            @(posedge clk); #1;
            lat++;
            if (lat == chg_at) bus.secret_key = key2;
        end
    endtask

    task automatic verify_run(input string tag, input logic [23:0] key, input int base,
                              input int lat, input int exp_lat);
        int mism;
        int smism;
        int idx;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " write count"}, wlog_n - base, 768);
        mism = 0;
        for (int n = 0; n < 768; n++) begin
            idx = (base + n) % LOG_SZ;
            if (wlog_a[idx] !== exp_wa[n] || wlog_d[idx] !== exp_wd[n]) mism++;
        end
        check({tag, " write sequence"}, mism, 0);
        smism = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) smism++;
        check({tag, " S dump"}, smism, 0);
        check({tag, " RAM released"}, 32'({bus.ksa_mem_handler, bus.memory_sel, bus.wen}), 0);
`ifdef KSA_CYCLE_COUNT_EN
        check({tag, " cycle_count at finish"}, 32'(bus.cycle_count), 2817);
`endif
        $display("[TB] run %s key=%06h latency=%0d writes=%0d", tag, key, lat, wlog_n - base);
    endtask

    typedef struct {
        logic [23:0] key;
        logic [23:0] key2;
        int          chg_at;
        int          exp_lat;
    } vec_t;

    vec_t       tv [5];
    logic [7:0] snap [256];
    int         lat;
    int         base;
    int         base0;
    int         bad;
    logic [23:0] hkey;
    logic [7:0] hw [12];

    initial begin
        bus.start_sig  = 1'b0;
        bus.secret_key = '0;

        tv[0] = '{24'h000000, 24'h000000, 0, 2818};
        tv[1] = '{24'h000001, 24'h000001, 0, 2818};
        tv[2] = '{24'($urandom), 24'h0, 0, 2818};
        tv[3] = '{24'($urandom), 24'h0, 0, 2818};
        tv[4].key     = 24'($urandom);
        tv[4].key2    = tv[4].key ^ 24'hA5A5A5;
        tv[4].chg_at  = 500;
        tv[4].exp_lat = 2818;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({bus.finish, bus.ksa_mem_handler, bus.memory_sel,
                                    bus.address, bus.data, bus.wen}), 0);
`ifdef KSA_CYCLE_COUNT_EN
        check("reset cycle_count", 32'(bus.cycle_count), 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle outputs", 32'({bus.finish, bus.ksa_mem_handler, bus.wen}), 0);

        // Table-driven runs with start pulses
        base0 = 0;
        for (int k = 0; k < 5; k++) begin
            model_ksa(tv[k].key);
            start_and_wait(tv[k].key, 1'b0, tv[k].chg_at, tv[k].key2, lat, base);
            if (k == 0) base0 = base;
            verify_run($sformatf("vec%0d", k), tv[k].key, base, lat, tv[k].exp_lat);
            @(posedge clk); #1;
            check($sformatf("vec%0d finish pulse end", k), 32'(bus.finish), 0);
        end

        // Key 0: identity fill and the first three swaps, written out by hand
        bad = 0;
        for (int n = 0; n < 256; n++) begin
            if (wlog_a[(base0 + n) % LOG_SZ] !== 8'(n) || wlog_d[(base0 + n) % LOG_SZ] !== 8'(n)) bad++;
        end
        check("key0 init writes", bad, 0);
        hw = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2};
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            if (wlog_a[(base0 + 256 + n) % LOG_SZ] !== hw[2*n] ||
                wlog_d[(base0 + 256 + n) % LOG_SZ] !== hw[2*n + 1]) bad++;
        end
        check("key0 first shuffle writes", bad, 0);

        // Handshake: start held through DONE, then dropped, then a second run
        hkey = 24'($urandom);
        model_ksa(hkey);
        start_and_wait(hkey, 1'b1, 0, hkey, lat, base);
        verify_run("hold", hkey, base, lat, 2818);
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (!(bus.finish === 1'b1 && bus.ksa_mem_handler === 1'b0 && bus.wen === 1'b0)) bad++;
        end
        check("held start no restart", bad, 0);
`ifdef KSA_CYCLE_COUNT_EN
        check("cycle_count held in DONE", 32'(bus.cycle_count), 2817);
`endif
        bus.start_sig = 1'b0;
        @(posedge clk); #1;
        check("finish drop after start low", 32'(bus.finish), 0);
        for (int n = 0; n < 256; n++) snap[n] = mem[n];
        start_and_wait(hkey, 1'b0, 0, hkey, lat, base);
        verify_run("rerun", hkey, base, lat, 2818);
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== snap[n]) bad++;
        check("rerun S identical", bad, 0);
        @(posedge clk); #1;

        // Reset in the middle of a run, then a full restart
        hkey = 24'($urandom);
        bus.secret_key = hkey;
        bus.start_sig  = 1'b1;
        @(posedge clk); #1;
        bus.start_sig = 1'b0;
        repeat (1000) begin
            @(posedge clk); #1;
        end
        check("owning RAM mid-run", 32'({bus.ksa_mem_handler, bus.memory_sel}), 32'h5);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid-run reset outputs", 32'({bus.finish, bus.ksa_mem_handler, bus.memory_sel,
                                            bus.address, bus.data, bus.wen}), 0);
`ifdef KSA_CYCLE_COUNT_EN
        check("mid-run reset cycle_count", 32'(bus.cycle_count), 0);
`endif
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle after reset", 32'({bus.ksa_mem_handler, bus.wen, bus.finish}), 0);
        model_ksa(hkey);
        start_and_wait(hkey, 1'b0, 0, hkey, lat, base);
        verify_run("restart", hkey, base, lat, 2818);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
